multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 148 ++++++++++++++
 tb/tb_multicycle_datapath.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle LW/SW/ADD/SUB/ADDI datapath; optional debug read port under MULTICYCLE_DATAPATH_DEBUG_EN.
// Latency: done 3 cycles after accept (READ, EXEC, WB), 4 for LW/SW (extra MEM cycle).
// Backpressure: op_ready only in IDLE; one operation in flight, inputs ignored until it retires.
module multicycle_datapath #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int DM_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [2:0]              op,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic [XLEN-1:0]         imm,
  output logic                    done,
  output logic [XLEN-1:0]         result,
  output logic                    err
`ifdef MULTICYCLE_DATAPATH_DEBUG_EN
  ,
  input  logic [$clog2(NREG)-1:0] dbg_raddr,
  output logic [XLEN-1:0]         dbg_rdata
`endif
);

  localparam int RW = $clog2(NREG);
  localparam int BW = $clog2(XLEN / 8);
  localparam int DW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  localparam logic [2:0] OP_LW   = 3'b000;
  localparam logic [2:0] OP_SW   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;

  typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} stateT;

  stateT           state, nextState;
  logic [2:0]      opQ;
  logic [RW-1:0]   rs1Q, rs2Q, rdQ;
  logic [XLEN-1:0] immQ, aVal, bVal, aluQ, resQ, aluOut, wordIdx, memRd;
  logic            errQ, isLegal, isMemOp, writesRd, addrFault, regWe, memWe;
  logic [DW-1:0]   memIdx;

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] mem  [DM_DEPTH];

  function automatic logic [XLEN-1:0] readReg(input logic [RW-1:0] idx);
    return (idx == '0) ? '0 : regs[idx];
  endfunction

  assign isLegal  = (opQ <= OP_ADDI);
  assign isMemOp  = (opQ == OP_LW) || (opQ == OP_SW);
  assign writesRd = isLegal && (opQ != OP_SW);

  always_comb begin
    aluOut = aVal + immQ;
    case (opQ)
      OP_ADD:  aluOut = aVal + bVal;
      OP_SUB:  aluOut = aVal - bVal;
      default: aluOut = aVal + immQ;
    endcase
  end

  // aluQ holds the byte address once a memory op reaches MEM
  assign wordIdx   = aluQ >> BW;
  assign addrFault = (|aluQ[BW-1:0]) || (wordIdx >= XLEN'(DM_DEPTH));
  assign memIdx    = wordIdx[DW-1:0];
  assign memRd     = mem[memIdx];
  assign memWe     = (state == MEM) && (opQ == OP_SW) && !addrFault;
  assign regWe     = (state == WB) && writesRd && !errQ && (rdQ != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (op_valid) nextState = READ;
      READ:    nextState = EXEC;
      EXEC:    nextState = isMemOp ? MEM : WB;
      MEM:     nextState = WB;
      WB:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign op_ready = (state == IDLE);
  assign done     = (state == WB);
  assign result   = done ? resQ : '0;
  assign err      = done && errQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opQ  <= '0;
      rs1Q <= '0;
      rs2Q <= '0;
      rdQ  <= '0;
      immQ <= '0;
      aVal <= '0;
      bVal <= '0;
      aluQ <= '0;
      resQ <= '0;
      errQ <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          opQ  <= op;
          rs1Q <= rs1;
          rs2Q <= rs2;
          rdQ  <= rd;
          immQ <= imm;
        end
        READ: begin
          aVal <= readReg(rs1Q);
          bVal <= readReg(rs2Q);
        end
        EXEC: begin
          aluQ <= aluOut;
          resQ <= isLegal ? aluOut : '0;
          errQ <= !isLegal;
        end
        MEM: begin
          if (opQ == OP_SW)    resQ <= bVal;
          else if (!addrFault) resQ <= memRd;
          errQ <= addrFault;
        end
        WB: if (regWe) regs[rdQ] <= resQ;
        default: ;
      endcase
    end
  end

  // Data memory deliberately has no reset; reset forces IDLE so memWe drops at once
  always_ff @(posedge clk) begin
    if (memWe) mem[memIdx] <= bVal;
  end

`ifdef MULTICYCLE_DATAPATH_DEBUG_EN
  assign dbg_rdata = readReg(dbg_raddr);
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath (default build, XLEN=64, NREG=32, DM_DEPTH=32).
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] imm;
  logic        done;
  logic [63:0] result;
  logic        err;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] LW = 3'b000, SW = 3'b001, ADD = 3'b010, SUB = 3'b011, ADDI = 3'b100;

  multicycle_datapath #(.XLEN(64), .NREG(32), .DM_DEPTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .imm      (imm),
    .done     (done),
    .result   (result),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, measure edges from accept (accept edge = 1) until done, check outputs.
  task automatic runOp(input string tag, input logic [2:0] o, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [63:0] im,
                       input int expLat, input logic chkRes, input logic [63:0] expRes,
                       input logic expErr);
    int lat;
    @(negedge clk);
    op_valid = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    checkVal({tag, "_ready"}, {63'd0, op_ready}, 64'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after capture; they must be ignored
    op_valid = 1'b0;
    op  = 3'($urandom);
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = {$urandom, $urandom};
    lat = 1;
    while (!done && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal({tag, "_lat"}, 64'(lat), 64'(expLat));
    if (chkRes) checkVal({tag, "_result"}, result, expRes);
    checkVal({tag, "_err"}, {63'd0, err}, {63'd0, expErr});
    @(posedge clk);
    #1;
    checkVal({tag, "_donepulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic peekReg(input string tag, input logic [4:0] idx, input logic [63:0] exp);
    runOp(tag, ADD, 5'd0, idx, 5'd0, 64'd0, 3, 1'b1, exp, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_ready",  {63'd0, op_ready}, 64'd1);
    checkVal("rst_done",   {63'd0, done},     64'd0);
    checkVal("rst_err",    {63'd0, err},      64'd0);
    checkVal("rst_result", result,            64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    runOp("addi_r1", ADDI, 5'd1, 5'd0, 5'd0, 64'd8, 3, 1'b1, 64'd8, 1'b0);
    runOp("addi_r2", ADDI, 5'd2, 5'd0, 5'd0, 64'd6, 3, 1'b1, 64'd6, 1'b0);
    runOp("add_r3",  ADD,  5'd3, 5'd1, 5'd2, 64'd0, 3, 1'b1, 64'd14, 1'b0);
    runOp("sub_r4",  SUB,  5'd4, 5'd3, 5'd1, 64'd0, 3, 1'b1, 64'd6, 1'b0);
    runOp("sub_neg", SUB,  5'd6, 5'd2, 5'd3, 64'd0, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    peekReg("peek_r6", 5'd6, 64'hFFFF_FFFF_FFFF_FFF8);

    runOp("sw_24",   SW, 5'd0, 5'd0, 5'd3, 64'd24, 4, 1'b1, 64'd14, 1'b0);
    runOp("lw_24",   LW, 5'd5, 5'd0, 5'd0, 64'd24, 4, 1'b1, 64'd14, 1'b0);
    peekReg("peek_r5", 5'd5, 64'd14);

    runOp("lw_mis",  LW, 5'd7, 5'd0, 5'd0, 64'd12, 4, 1'b0, 64'd0, 1'b1);
    peekReg("peek_r7", 5'd7, 64'd0);
    runOp("sw_w0",   SW, 5'd0, 5'd0, 5'd2, 64'd0, 4, 1'b1, 64'd6, 1'b0);
    runOp("sw_oob",  SW, 5'd0, 5'd0, 5'd1, 64'd256, 4, 1'b0, 64'd0, 1'b1);
    runOp("lw_w0",   LW, 5'd0, 5'd0, 5'd0, 64'd0, 4, 1'b1, 64'd6, 1'b0);
    runOp("lw_w3",   LW, 5'd0, 5'd0, 5'd0, 64'd24, 4, 1'b1, 64'd14, 1'b0);

    runOp("illegal", 3'b111, 5'd1, 5'd3, 5'd3, 64'd1, 3, 1'b0, 64'd0, 1'b1);
    peekReg("peek_r1", 5'd1, 64'd8);
    runOp("addi_r0", ADDI, 5'd0, 5'd0, 5'd0, 64'd5, 3, 1'b1, 64'd5, 1'b0);
    peekReg("peek_r0", 5'd0, 64'd0);

    runOp("sw_w4",   SW, 5'd0, 5'd0, 5'd3, 64'd32, 4, 1'b1, 64'd14, 1'b0);

    // Reset during MEM of a store of r1 (8) to word 4
    @(negedge clk);
    op_valid = 1'b1; op = SW; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd1; imm = 64'd32;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkVal("midrst_ready",  {63'd0, op_ready}, 64'd1);
    checkVal("midrst_done",   {63'd0, done},     64'd0);
    checkVal("midrst_err",    {63'd0, err},      64'd0);
    checkVal("midrst_result", result,            64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    runOp("lw_w4", LW, 5'd0, 5'd0, 5'd0, 64'd32, 4, 1'b1, 64'd14, 1'b0);
    for (int i = 1; i < 8; i++) peekReg($sformatf("rstreg_r%0d", i), 5'(i), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
